// File: rtl/data_memory_unit.sv
// MEM-stage data memory with registered read and write-back select.
// Returns the stored word on loads, or the address as the ALU-result passthrough.
module data_memory_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    output logic [DATA_W-1:0] read_data
);

    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] read_data_d;
    logic [DATA_W-1:0] word;

    assign idx = address[ADDR_W-1:0];

    // Valid bits make a one-cycle clear-all; unwritten words read as zero.
    assign word = valid_q[idx] ? mem_q[idx] : '0;

    always_comb begin
        valid_d     = valid_q;
        read_data_d = read_data_q;
        if (MemWrite) begin
            valid_d[idx] = 1'b1;
        end
        if (MemRead) begin
            read_data_d = MemtoReg ? word : address;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            read_data_q <= '0;
        end else begin
            valid_q     <= valid_d;
            read_data_q <= read_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && MemWrite) begin
            mem_q[idx] <= write_data;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_data_memory_unit;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic [31:0] read_data;

    int n_checks;
    int n_pass;

    data_memory_unit dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .write_data (write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] a,
                        input logic [31:0] wd, input logic rd,
                        input logic wr, input logic m2r);
        @(negedge clk);
        rst        = r;
        address    = a;
        write_data = wd;
        MemRead    = rd;
        MemWrite   = wr;
        MemtoReg   = m2r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        address    = '0;
        write_data = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;

        step(1, 32'h0, 32'h0, 0, 0, 0);
        check("reset", read_data, 32'h0);

        step(0, 32'h4, 32'hDEADBEEF, 0, 1, 1);
        check("store_hold", read_data, 32'h0);
        step(0, 32'h4, 32'h0, 1, 0, 1);
        check("load_4", read_data, 32'hDEADBEEF);
        step(0, 32'h4, 32'h0, 1, 0, 0);
        check("pass_4", read_data, 32'h00000004);

        step(0, 32'h8, 32'hCAFEBABE, 0, 1, 0);
        step(0, 32'h8, 32'h0, 1, 0, 1);
        check("load_8", read_data, 32'hCAFEBABE);
        step(0, 32'h8, 32'h0, 1, 0, 0);
        check("pass_8", read_data, 32'h00000008);

        // Reset wins over simultaneous read and write.
        step(1, 32'h4, 32'hFFFFFFFF, 1, 1, 1);
        check("mid_reset", read_data, 32'h0);
        step(0, 32'h4, 32'h0, 1, 0, 1);
        check("cleared_4", read_data, 32'h0);
        step(0, 32'h8, 32'h0, 1, 0, 1);
        check("cleared_8", read_data, 32'h0);

        step(0, 32'hA, 32'h0DE07A01, 0, 1, 0);
        step(0, 32'hA, 32'h0, 1, 0, 1);
        check("load_A", read_data, 32'h0DE07A01);
        step(0, 32'hA, 32'h0, 1, 0, 0);
        check("pass_A", read_data, 32'h0000000A);
        step(0, 32'h8, 32'h0, 1, 0, 1);
        check("distinct_8", read_data, 32'h0);

        step(0, 32'h20, 32'h11, 0, 1, 0);
        step(0, 32'h20, 32'h22, 1, 1, 1);
        check("rbw_old", read_data, 32'h00000011);
        step(0, 32'h33, 32'h0, 0, 0, 0);
        check("idle_1", read_data, 32'h00000011);
        step(0, 32'h20, 32'h0, 0, 0, 1);
        check("idle_2", read_data, 32'h00000011);
        step(0, 32'h20, 32'h0, 1, 0, 1);
        check("rbw_new", read_data, 32'h00000022);

        // Upper address bits are ignored for indexing but kept on passthrough.
        step(0, 32'h120, 32'h0, 1, 0, 1);
        check("alias_load", read_data, 32'h00000022);
        step(0, 32'h120, 32'h0, 1, 0, 0);
        check("alias_pass", read_data, 32'h00000120);
        step(0, 32'hFF, 32'h0, 1, 0, 1);
        check("unwritten", read_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
